// File: rtl/button_debounce_multi_if.sv
// Signal bundle for the multi-channel button debouncer: the sampling tick and
// raw buttons going in, the clean level and event pulses coming back out.
interface button_debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic                slow_clk;
  logic [CHANNELS-1:0] button_in;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] long_press_pulse;
  logic [CHANNELS-1:0] repeat_pulse;

  // Side that owns the pads and the tick, and consumes the events
  modport master (
    output slow_clk,
    output button_in,
    input  level_out,
    input  press_pulse,
    input  release_pulse,
    input  long_press_pulse,
    input  repeat_pulse
  );

  // Debouncer side
  modport slave (
    input  slow_clk,
    input  button_in,
    output level_out,
    output press_pulse,
    output release_pulse,
    output long_press_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/button_debounce_multi.sv
// Multi-channel push-button debouncer. Each channel synchronises its raw pad,
// qualifies a level change over several slow sampling ticks, and then runs a
// small press/hold FSM producing press, release, long-press and auto-repeat
// pulses. slow_clk is only an enable; every register lives on regular_clk.
module button_debounce_multi #(
  parameter int CHANNELS     = 4,
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 200,
  parameter int REPEAT_TICKS = 50,
  parameter int REPEAT_EN    = 1
) (
  input  logic                     regular_clk,
  input  logic                     reset,
  button_debounce_multi_if.slave   bus
);

  localparam int STABLE_W = $clog2(STABLE_TICKS + 1);
  localparam int HOLD_W   = $clog2(HOLD_TICKS + 1);
  localparam int REP_W    = $clog2(REPEAT_TICKS + 1);

  // Terminal values: the tick that would make the count reach its limit
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_TICKS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [REP_W-1:0]    REP_LAST    = REP_W'(REPEAT_TICKS - 1);
  localparam logic                REPEAT_ON   = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } chanState_e;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChan
    logic                syncA_q;
    logic                syncB_q;
    logic                level_q,     level_d;
    logic [STABLE_W-1:0] stableCnt_q, stableCnt_d;
    logic [HOLD_W-1:0]   holdCnt_q,   holdCnt_d;
    logic [REP_W-1:0]    repCnt_q,    repCnt_d;
    chanState_e          state_q,     state_d;
    logic                press_q,     press_d;
    logic                release_q,   release_d;
    logic                long_q,      long_d;
    logic                repeat_q,    repeat_d;

    // Two-flop synchroniser bringing the asynchronous pad into regular_clk
    always_ff @(posedge regular_clk or posedge reset) begin
      if (reset) begin
        syncA_q <= 1'b0;
        syncB_q <= 1'b0;
      end else begin
        syncA_q <= bus.button_in[ch];
        syncB_q <= syncA_q;
      end
    end

    // Debounce qualification and press/hold/repeat FSM next-state logic
    always_comb begin
      level_d     = level_q;
      stableCnt_d = stableCnt_q;
      holdCnt_d   = holdCnt_q;
      repCnt_d    = repCnt_q;
      state_d     = state_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;

      if (bus.slow_clk) begin
        if (syncB_q != level_q) begin
          if (stableCnt_q == STABLE_LAST) begin
            stableCnt_d = '0;
            level_d     = ~level_q;
            press_d     = ~level_q;
            release_d   = level_q;
          end else begin
            stableCnt_d = stableCnt_q + 1'b1;
          end
        end else begin
          stableCnt_d = '0;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d   = PRESSED;
            holdCnt_d = '0;
            repCnt_d  = '0;
          end
        end
        PRESSED: begin
          if (release_d) begin
            state_d   = IDLE;
            holdCnt_d = '0;
            repCnt_d  = '0;
          end else if (bus.slow_clk) begin
            if (holdCnt_q == HOLD_LAST) begin
              state_d   = HELD;
              long_d    = 1'b1;
              holdCnt_d = '0;
              repCnt_d  = '0;
            end else begin
              holdCnt_d = holdCnt_q + 1'b1;
            end
          end
        end
        HELD: begin
          if (release_d) begin
            state_d   = IDLE;
            holdCnt_d = '0;
            repCnt_d  = '0;
          end else if (bus.slow_clk) begin
            if (repCnt_q == REP_LAST) begin
              repeat_d = REPEAT_ON;
              repCnt_d = '0;
            end else begin
              repCnt_d = repCnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          holdCnt_d = '0;
          repCnt_d  = '0;
        end
      endcase
    end

    // Channel state, counters and registered event pulses
    always_ff @(posedge regular_clk or posedge reset) begin
      if (reset) begin
        level_q     <= 1'b0;
        stableCnt_q <= '0;
        holdCnt_q   <= '0;
        repCnt_q    <= '0;
        state_q     <= IDLE;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        level_q     <= level_d;
        stableCnt_q <= stableCnt_d;
        holdCnt_q   <= holdCnt_d;
        repCnt_q    <= repCnt_d;
        state_q     <= state_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    assign bus.level_out[ch]        = level_q;
    assign bus.press_pulse[ch]      = press_q;
    assign bus.release_pulse[ch]    = release_q;
    assign bus.long_press_pulse[ch] = long_q;
    assign bus.repeat_pulse[ch]     = repeat_q;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for the multi-channel debouncer: directed scenarios plus random button
// activity, compared every cycle against a tick-history model. A second
// instance built without auto-repeat shares the same stimulus.
module tb_button_debounce_multi;

  localparam int CH          = 4;
  localparam int STABLE      = 4;
  localparam int HOLD        = 8;
  localparam int REPEAT      = 3;
  localparam int TICK_PERIOD = 10;

  logic          regular_clk = 1'b0;
  logic          reset       = 1'b0;
  logic          slowDrive   = 1'b0;
  logic [CH-1:0] btnDrive    = '0;
  bit            contMode    = 1'b0;
  int            phase       = 0;
  int            tickCount   = 0;

  int checks   = 0;
  int failures = 0;

  button_debounce_multi_if #(.CHANNELS(CH)) busA ();
  button_debounce_multi_if #(.CHANNELS(CH)) busB ();

  assign busA.slow_clk  = slowDrive;
  assign busA.button_in = btnDrive;
  assign busB.slow_clk  = slowDrive;
  assign busB.button_in = btnDrive;

  button_debounce_multi #(
    .CHANNELS(CH), .STABLE_TICKS(STABLE), .HOLD_TICKS(HOLD),
    .REPEAT_TICKS(REPEAT), .REPEAT_EN(1)
  ) dutA (
    .regular_clk(regular_clk),
    .reset(reset),
    .bus(busA.slave)
  );

  button_debounce_multi #(
    .CHANNELS(CH), .STABLE_TICKS(STABLE), .HOLD_TICKS(HOLD),
    .REPEAT_TICKS(REPEAT), .REPEAT_EN(0)
  ) dutB (
    .regular_clk(regular_clk),
    .reset(reset),
    .bus(busB.slave)
  );

  always #5 regular_clk = ~regular_clk;

  // Running count of sampling ticks seen by the design
  always @(posedge regular_clk) begin
    if (slowDrive) tickCount++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $time, actual, actual, expected, expected);
    end
  endtask

  // Reference model: the pad value seen two clocks later; level flips after
  // STABLE consecutive disagreeing ticks; while pressed, count ticks since the
  // rise and derive long/repeat events arithmetically from that count.
  logic [CH-1:0] pipe1, pipe2, synced;
  logic [CH-1:0] mLevel;
  int            run [CH];
  bit            pressed [CH];
  int            heldTicks [CH];
  logic [CH-1:0] expLevel, expPress, expRelease, expLong, expRepeat;

  always @(posedge regular_clk or posedge reset) begin
    if (reset) begin
      pipe1 = '0; pipe2 = '0; mLevel = '0;
      expLevel = '0; expPress = '0; expRelease = '0; expLong = '0; expRepeat = '0;
      for (int k = 0; k < CH; k++) begin
        run[k] = 0; pressed[k] = 1'b0; heldTicks[k] = 0;
      end
    end else begin
      synced = pipe2;
      pipe2  = pipe1;
      pipe1  = btnDrive;
      expPress = '0; expRelease = '0; expLong = '0; expRepeat = '0;
      if (slowDrive) begin
        for (int k = 0; k < CH; k++) begin
          run[k] = (synced[k] != mLevel[k]) ? run[k] + 1 : 0;
          if (run[k] == STABLE) begin
            run[k]    = 0;
            mLevel[k] = ~mLevel[k];
            if (mLevel[k]) begin
              expPress[k]  = 1'b1;
              pressed[k]   = 1'b1;
              heldTicks[k] = 0;
            end else begin
              expRelease[k] = 1'b1;
              pressed[k]    = 1'b0;
              heldTicks[k]  = 0;
            end
          end else if (pressed[k]) begin
            heldTicks[k]++;
            if (heldTicks[k] == HOLD)
              expLong[k] = 1'b1;
            else if (heldTicks[k] > HOLD && ((heldTicks[k] - HOLD) % REPEAT) == 0)
              expRepeat[k] = 1'b1;
          end
        end
      end
      expLevel = mLevel;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge regular_clk) begin
    checkOutput("levelA",   busA.level_out,        expLevel);
    checkOutput("pressA",   busA.press_pulse,      expPress);
    checkOutput("releaseA", busA.release_pulse,    expRelease);
    checkOutput("longA",    busA.long_press_pulse, expLong);
    checkOutput("repeatA",  busA.repeat_pulse,     expRepeat);
    checkOutput("levelB",   busB.level_out,        expLevel);
    checkOutput("pressB",   busB.press_pulse,      expPress);
    checkOutput("releaseB", busB.release_pulse,    expRelease);
    checkOutput("longB",    busB.long_press_pulse, expLong);
    checkOutput("repeatB",  busB.repeat_pulse,     0);
  end

  // Event log of instance A used by the hand-computed scenario checks
  int            pressCount [CH], releaseCount [CH], longCount [CH], repeatCount [CH];
  int            lastPressTick [CH], firstLongTick [CH], firstRepeatTick [CH], lastRepeatTick [CH];
  int            pressEvents;
  logic [CH-1:0] lastPressVec;

  always @(negedge regular_clk) begin
    if (!reset) begin
      for (int k = 0; k < CH; k++) begin
        if (busA.press_pulse[k]) begin
          pressCount[k]++;
          lastPressTick[k] = tickCount;
        end
        if (busA.release_pulse[k]) releaseCount[k]++;
        if (busA.long_press_pulse[k]) begin
          if (longCount[k] == 0) firstLongTick[k] = tickCount;
          longCount[k]++;
        end
        if (busA.repeat_pulse[k]) begin
          if (repeatCount[k] == 0) firstRepeatTick[k] = tickCount;
          repeatCount[k]++;
          lastRepeatTick[k] = tickCount;
        end
      end
      if (busA.press_pulse != '0) begin
        pressEvents++;
        lastPressVec = busA.press_pulse;
      end
    end
  end

  task automatic clearMonitor();
    for (int k = 0; k < CH; k++) begin
      pressCount[k] = 0; releaseCount[k] = 0; longCount[k] = 0; repeatCount[k] = 0;
      lastPressTick[k] = -1000; firstLongTick[k] = -1000;
      firstRepeatTick[k] = -1000; lastRepeatTick[k] = -1000;
    end
    pressEvents  = 0;
    lastPressVec = '0;
  endtask

  // One regular_clk cycle; the tick lands mid-period so input changes made
  // at a period boundary are through the synchroniser before the next tick
  task automatic stepCycle();
    @(posedge regular_clk);
    #2;
    slowDrive = contMode ? 1'b1 : (phase == TICK_PERIOD / 2);
    phase     = (phase + 1) % TICK_PERIOD;
  endtask

  task automatic applyStimulus(input logic [CH-1:0] btn, input int nTicks);
    btnDrive = btn;
    repeat (contMode ? nTicks : nTicks * TICK_PERIOD) stepCycle();
  endtask

  int changeTick;

  initial begin
    clearMonitor();
    #1 reset = 1'b1;
    repeat (TICK_PERIOD) stepCycle();
    checkOutput("resetLevel", busA.level_out, 0);
    checkOutput("resetPulses", busA.press_pulse | busA.long_press_pulse, 0);
    reset = 1'b0;

    // Clean press on channel 0
    clearMonitor();
    changeTick = tickCount;
    applyStimulus(4'b0001, 6);
    checkOutput("cleanPressDelay", lastPressTick[0] - changeTick, 4);
    checkOutput("cleanPressCount", pressCount[0], 1);
    checkOutput("cleanOtherPress", pressCount[1] + pressCount[2] + pressCount[3], 0);
    applyStimulus(4'b0000, 6);
    checkOutput("cleanReleaseCount", releaseCount[0], 1);

    // Bouncing channel 1: toggles every 2 ticks, never qualifies
    clearMonitor();
    for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 4'b0010 : 4'b0000, 2);
    applyStimulus(4'b0000, 6);
    checkOutput("bounceEvents", pressCount[1] + releaseCount[1], 0);

    // Long press and repeat on channel 2
    clearMonitor();
    changeTick = tickCount;
    applyStimulus(4'b0100, 30);
    applyStimulus(4'b0000, 6);
    checkOutput("longPressDelay", lastPressTick[2] - changeTick, 4);
    checkOutput("longOffset", firstLongTick[2] - lastPressTick[2], 8);
    checkOutput("longCount", longCount[2], 1);
    checkOutput("firstRepeatOffset", firstRepeatTick[2] - lastPressTick[2], 11);
    checkOutput("lastRepeatOffset", lastRepeatTick[2] - lastPressTick[2], 29);
    checkOutput("repeatCount", repeatCount[2], 7);
    checkOutput("longReleaseCount", releaseCount[2], 1);

    // Channel 3 released before the hold time
    clearMonitor();
    applyStimulus(4'b1000, 5);
    applyStimulus(4'b0000, 6);
    checkOutput("shortPress", pressCount[3], 1);
    checkOutput("shortRelease", releaseCount[3], 1);
    checkOutput("shortNoLong", longCount[3], 0);

    // Simultaneous presses on channels 0 and 3
    clearMonitor();
    applyStimulus(4'b1001, 6);
    checkOutput("simulPressVec", lastPressVec, 4'b1001);
    checkOutput("simulPressEvents", pressEvents, 1);
    applyStimulus(4'b0000, 6);

    // Reset while all buttons are held and debounced high
    applyStimulus(4'b1111, 12);
    reset = 1'b1;
    #1;
    checkOutput("midResetLevel", busA.level_out, 0);
    checkOutput("midResetPulses",
                busA.press_pulse | busA.release_pulse | busA.long_press_pulse | busA.repeat_pulse, 0);
    repeat (TICK_PERIOD - 1) stepCycle();
    @(posedge regular_clk);
    #2;
    slowDrive = 1'b0;
    phase     = 0;
    reset     = 1'b0;
    clearMonitor();
    changeTick = tickCount;
    applyStimulus(4'b1111, 6);
    checkOutput("postResetDelay", lastPressTick[0] - changeTick, 4);
    checkOutput("postResetVec", lastPressVec, 4'b1111);
    applyStimulus(4'b0000, 6);

    // Random activity with the periodic tick
    for (int i = 0; i < 60; i++)
      applyStimulus(CH'($urandom_range(0, 15)), $urandom_range(1, 15));

    // Random activity with slow_clk held high every cycle
    contMode = 1'b1;
    for (int i = 0; i < 80; i++)
      applyStimulus(CH'($urandom_range(0, 15)), $urandom_range(1, 20));
    contMode = 1'b0;
    applyStimulus(4'b0000, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
Parametrised, multi-channel successor to the single-button debouncer. Debounces CHANNELS independent push-buttons using a shared slow sampling tick. Per channel it provides a clean level plus single-cycle press, release, long-press and auto-repeat pulses. Sits between the raw pad inputs and the UI/control FSMs (mode select, time set) on the 31.5 MHz domain.

Parameters:
CHANNELS, 4, number of independent button channels (>=1)
STABLE_TICKS, 4, consecutive slow_clk samples of a new value required before level changes (>=1)
HOLD_TICKS, 200, slow_clk ticks of continuous press before long_press_pulse (>=1)
REPEAT_TICKS, 50, slow_clk ticks between successive repeat_pulse after long press (>=1)
REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = repeat_pulse tied low

Ports:
regular_clk  in  1  system clock, 31.5 MHz
reset  in  1  asynchronous, active-high reset
slow_clk  in  1  sampling tick enable, high for one regular_clk cycle per period (~1.25 ms)
button_in  in  CHANNELS  raw asynchronous button inputs, active-high
level_out  out  CHANNELS  debounced button level
press_pulse  out  CHANNELS  one-cycle pulse on debounced rising edge
release_pulse  out  CHANNELS  one-cycle pulse on debounced falling edge
long_press_pulse  out  CHANNELS  one-cycle pulse when held HOLD_TICKS
repeat_pulse  out  CHANNELS  one-cycle pulse every REPEAT_TICKS after long press

Behaviour:
- One clock: regular_clk; reset asynchronous active-high. All state on regular_clk only; slow_clk is an enable, never a clock.
- Reset: all outputs 0, synchronisers 0, all counters 0, every channel FSM in IDLE. Reset mid-press: no pulse emitted on or after deassertion until a fresh STABLE_TICKS qualification.
- Per channel, button_in passes a 2-flop synchroniser (2-cycle latency) before sampling.
- Stability counter (width $clog2(STABLE_TICKS+1)): on a slow_clk cycle, if sync value != level_out, increment; else clear. When increment would reach STABLE_TICKS, level_out toggles next cycle and counter clears. Non-tick cycles hold counter.
- press_pulse/release_pulse: registered, asserted in exactly the cycle level_out first shows the new value; high one regular_clk cycle.
- Channel FSM: IDLE (level 0) -> PRESSED on debounced rise; PRESSED counts slow_clk ticks from 0; on reaching HOLD_TICKS -> HELD, long_press_pulse one cycle, repeat counter cleared; HELD counts ticks, each REPEAT_TICKS -> repeat_pulse one cycle (only if REPEAT_EN), counter wraps to 0; stays HELD. Debounced fall from any state -> IDLE, all counters cleared, no long/repeat pulse in that cycle.
- Hold and repeat counters sized $clog2(max+1); never overflow (compare-and-clear).
- Tick ordering: press detected on tick N; hold count starts at tick N+1; long_press_pulse follows tick N+HOLD_TICKS; first repeat follows tick N+HOLD_TICKS+REPEAT_TICKS.
- Channels fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- Glitch shorter than STABLE_TICKS ticks: no output change, no pulses.
- slow_clk held high continuously: treated as a tick every cycle (legal, used in simulation).
- At most one of press/release/long/repeat pulse active per channel per cycle.

Test Plan:
- Reset: assert reset mid-operation with button_in=4'b1111, level high -> all outputs 0 within same cycle; after release of reset, level_out stays 0 until 4 ticks of stable input.
- Clean press ch0 (STABLE_TICKS=4, slow_clk every 10 cycles): hold button_in[0]=1 -> level_out[0]=1 and press_pulse[0]=1 for one cycle right after 4th tick; other channels idle.
- Bounce: toggle ch1 every 2 ticks for 20 ticks -> no level change, no pulses; then stable 0 -> still 0.
- Long press/repeat (HOLD_TICKS=8, REPEAT_TICKS=3): hold ch2 30 ticks -> one long_press_pulse at press+8 ticks, repeat_pulse at +11, +14, +17 ... ; release -> release_pulse once, no further repeats.
- Release before hold: press ch3 for 5 ticks after qualification -> press and release pulses only, no long_press_pulse.
- Simultaneous: press ch0 and ch3 same cycle -> press_pulse=4'b1001 in a single cycle; REPEAT_EN=0 build -> repeat_pulse always 0.
